// File: rtl/prio_enc_rr.sv
// prio_enc_rr: registered priority encoder with a fixed (highest-bit-wins)
// mode and a round-robin mode that rotates a grant pointer. One result is
// held at a time; a new request can load on the same edge the old one leaves.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side. in_ready = !out_valid || out_ready, so the single
// result register never overflows. The result (code/none/out_valid) stays
// frozen while out_valid && !out_ready, and input is ignored in that case.
module prio_enc_rr #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           req,
  input  logic                       mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH)-1:0]   code,
  output logic                       none
);

  localparam int IDX_W = $clog2(WIDTH);

  // ptr holds the last round-robin grant; the search starts just above it.
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] fix_code;
  logic [IDX_W-1:0] rr_code;
  logic             rr_found;
  int               rr_idx;
  logic             accept;
  logic             req_zero;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign req_zero = (req == '0);

  // Fixed priority: scanning upward lets the highest set bit win.
  always_comb begin
    fix_code = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) fix_code = IDX_W'(i);
    end
  end

  // Round-robin: first set bit at ptr+1, ptr+2, ... wrapping, ptr itself last.
  always_comb begin
    rr_code  = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 1; k <= WIDTH; k++) begin
      rr_idx = (int'(ptr) + k) % WIDTH;
      if (!rr_found && req[rr_idx]) begin
        rr_code  = IDX_W'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  // Result register and grant pointer; reset clears any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      code      <= '0;
      none      <= 1'b0;
      ptr       <= IDX_W'(WIDTH - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      none      <= req_zero;
      if (req_zero) begin
        code <= '0;
      end else if (mode) begin
        code <= rr_code;
        ptr  <= rr_code;
      end else begin
        code <= fix_code;
      end
    end else if (out_ready) begin
      // Consumed with nothing new arriving: the register empties.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_enc_rr.sv
// Bench for prio_enc_rr (WIDTH=8): directed steps plus random traffic,
// each cycle compared against a behavioural model of the handshake,
// the highest-set-bit rule and the rotating round-robin rule.
module tb_prio_enc_rr;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] req;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] code;
  logic       none;

  int checks = 0;
  int errors = 0;

  // model state
  int m_valid;
  int m_code;
  int m_none;
  int m_ptr;

  prio_enc_rr #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code      (code),
    .none      (none)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int hi_bit(input logic [7:0] r);
    for (int i = 7; i >= 0; i--) if (r[i]) return i;
    return 0;
  endfunction

  function automatic int rr_pick(input logic [7:0] r, input int p);
    for (int k = 1; k <= 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_code  = 0;
    m_none  = 0;
    m_ptr   = 7;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid), m_valid);
    chk({tag, ".code"},      int'(code),      m_code);
    chk({tag, ".none"},      int'(none),      m_none);
  endtask

  // Driver: apply inputs, check in_ready, advance one edge, check outputs.
  task automatic drive(input string tag, input logic iv, input logic [7:0] r,
                       input logic md, input logic ordy);
    int ir;
    in_valid  = iv;
    req       = r;
    mode      = md;
    out_ready = ordy;
    #1;
    ir = (m_valid == 0 || ordy) ? 1 : 0;
    chk({tag, ".in_ready"}, int'(in_ready), ir);
    if (iv && ir == 1) begin
      m_valid = 1;
      if (r == 8'h00) begin
        m_code = 0;
        m_none = 1;
      end else begin
        m_none = 0;
        m_code = md ? rr_pick(r, m_ptr) : hi_bit(r);
        if (md) m_ptr = m_code;
      end
    end else if (m_valid == 1 && ordy) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk_outputs(tag);
  endtask

  initial begin
    int rr_exp[9];
    int saved_code;
    int saved_none;
    logic [7:0] r;
    rr_exp = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    req = 8'h00;
    mode = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // reset state
    #3;
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.code", int'(code), 0);
    chk("reset.none", int'(none), 0);
    chk("reset.in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // fixed encoding, first acceptance on the first edge after reset
    drive("fix_first", 1'b1, 8'b0000_1001, 1'b0, 1'b1);
    chk("fix_first.lit_code", int'(code), 3);
    for (int v = 0; v < 256; v++) drive("fix_sweep", 1'b1, 8'(v), 1'b0, 1'b1);

    // round-robin rotation from reset pointer
    for (int i = 0; i < 9; i++) begin
      drive("rr_ff", 1'b1, 8'hFF, 1'b1, 1'b1);
      chk("rr_ff.lit_code", int'(code), rr_exp[i]);
    end
    drive("rr_two", 1'b1, 8'b1000_0100, 1'b1, 1'b1);
    chk("rr_two.lit0", int'(code), 2);
    drive("rr_two", 1'b1, 8'b1000_0100, 1'b1, 1'b1);
    chk("rr_two.lit1", int'(code), 7);
    drive("rr_two", 1'b1, 8'b1000_0100, 1'b1, 1'b1);
    chk("rr_two.lit2", int'(code), 2);

    // zero request leaves the pointer at 2
    drive("zero", 1'b1, 8'h00, 1'b1, 1'b1);
    chk("zero.lit_code", int'(code), 0);
    chk("zero.lit_none", int'(none), 1);
    drive("zero_after", 1'b1, 8'hFF, 1'b1, 1'b1);
    chk("zero_after.lit_code", int'(code), 3);

    // backpressure: result frozen while req toggles
    drive("bp_load", 1'b1, 8'hFF, 1'b1, 1'b1);
    saved_code = int'(code);
    saved_none = int'(none);
    for (int i = 0; i < 5; i++) begin
      drive("bp_hold", 1'b1, 8'($urandom), 1'($urandom), 1'b0);
      chk("bp_hold.lit_in_ready", int'(in_ready), 0);
      chk("bp_hold.frozen_code", int'(code), saved_code);
      chk("bp_hold.frozen_none", int'(none), saved_none);
      chk("bp_hold.frozen_valid", int'(out_valid), 1);
    end
    drive("bp_release", 1'b1, 8'h20, 1'b0, 1'b1);
    chk("bp_release.lit_code", int'(code), 5);
    drive("drain", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain.lit_valid", int'(out_valid), 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 8'h00;
        1:       r = 8'(1) << $urandom_range(0, 7);
        default: r = 8'($urandom);
      endcase
      drive("rand", 1'($urandom_range(0, 3) != 0), r, 1'($urandom),
            1'($urandom_range(0, 3) != 0));
    end

    // reset mid-operation, holding a result under backpressure
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive("mid_rr", 1'b1, 8'hFF, 1'b1, 1'b1);
      chk("mid_rr.lit_code", int'(code), i);
    end
    drive("mid_hold", 1'b1, 8'hFF, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst.out_valid", int'(out_valid), 0);
    chk("mid_rst.code", int'(code), 0);
    chk("mid_rst.none", int'(none), 0);
    chk("mid_rst.in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive("post_rst", 1'b1, 8'hFF, 1'b1, 1'b1);
    chk("post_rst.lit_code", int'(code), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_enc_rr.md
PRIO_ENC_RR -- requirements
Module: prio_enc_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the request vector width (legal range 2..64).
REQ-002 The block SHALL have localparam IDX_W, equal to $clog2(WIDTH), giving the code width (3 for WIDTH=8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: req/mode are valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-007 The block SHALL have port req, input, WIDTH bits: request vector to encode.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 selects fixed priority, 1 selects round-robin; sampled with req.
REQ-009 The block SHALL have port out_valid, output, 1 bit: code/none hold a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumes the result this cycle.
REQ-011 The block SHALL have port code, output, IDX_W bits: encoded index of the granted request.
REQ-012 The block SHALL have port none, output, 1 bit: the accepted req was all zeros.

Function
REQ-013 The block SHALL drive in_ready combinationally as (!out_valid || out_ready), giving single-entry full throughput.
REQ-014 The block SHALL accept input when in_valid && in_ready, and SHALL register the result with out_valid=1 on the next edge (1-cycle latency).
REQ-015 The block SHALL set out_valid to 0 on the edge where out_valid && out_ready && !in_valid.
REQ-016 The block SHALL hold code, none and out_valid stable while out_valid && !out_ready.
REQ-017 In fixed mode (mode=0), code SHALL be the index of the highest set bit of req.
REQ-018 In round-robin mode (mode=1), code SHALL be the first set bit found searching upward from index ptr+1, wrapping from WIDTH-1 to 0, with ptr itself checked last.
REQ-019 The block SHALL hold an internal IDX_W-bit pointer ptr, which updates to the granted code only on an accepted mode=1 transfer with req!=0.
REQ-020 Fixed-mode transfers and zero-req transfers SHALL leave ptr unchanged.
REQ-021 For an accepted req==0 in either mode, the block SHALL register code=0 and none=1; otherwise none=0.
REQ-022 When out_valid && out_ready && in_valid occur in the same cycle, the block SHALL output the old result and load the new result on that edge with no bubble.
REQ-023 While in_ready=0, the block SHALL ignore req, mode and in_valid entirely; ptr and outputs SHALL not change.
REQ-024 When a single request bit is set, code SHALL equal that bit's index in both modes.

Reset
REQ-025 While rst_n=0, asynchronously and independent of clk, the block SHALL force out_valid=0, code=0, none=0 and ptr=WIDTH-1, so the first round-robin search starts at index 0.
REQ-026 A reset asserted mid-transfer SHALL discard any held result; no partial state SHALL survive.
REQ-027 While in reset, in_ready SHALL read 1, since out_valid=0.
REQ-028 The first acceptance SHALL occur on the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-029 Reset check: assert rst_n=0 between clock edges -> out_valid=0, code=0, none=0 and in_ready=1 immediately.
REQ-030 Fixed encoding: mode=0, req=8'b0000_1001, out_ready=1 -> next cycle out_valid=1, code=3, none=0; then sweep req=0..255 and compare against the highest-set-bit model.
REQ-031 Round-robin rotation: mode=1, req=8'hFF held with in_valid=1 and out_ready=1 for 9 cycles -> codes 0,1,2,3,4,5,6,7,0; with req=8'b1000_0100, the sequence SHALL be 2,7,2.
REQ-032 Zero request: mode=1 with ptr=2, apply req=0 -> code=0, none=1; then req=8'hFF -> code=3, confirming ptr was unchanged.
REQ-033 Backpressure: hold out_ready=0 after one result -> in_ready=0 and code/none/out_valid frozen for 5 cycles while req toggles; release -> old result consumed, new one loaded the same edge.
REQ-034 Reset mid-operation: after round-robin grants 0,1,2, pulse rst_n low for half a cycle -> outputs cleared; the next req=8'hFF in mode=1 SHALL yield code=0.
